// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: arbitrates ALU/MEM writeback and sequences the IRQ link save.
// Build option: define WB_ROUND_ROBIN_EN for round-robin ALU/MEM arbitration (default: MEM > ALU).
module regfile_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31,
  parameter int PC_INC   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              IRQ,
  input  logic [DATA_W-1:0] PC,
  output logic              irq_ack,
  output logic              WrC,
  output logic [ADDR_W-1:0] AddrC,
  output logic [DATA_W-1:0] WriteDataC
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t state, state_nxt;

  logic              irq_take_p0;
  logic              alu_gnt_p0;
  logic              mem_gnt_p0;
  logic [ADDR_W-1:0] sel_addr_p0;
  logic [DATA_W-1:0] sel_data_p0;
  logic              vld_p0;

  logic              vld_p1;
  logic              ack_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] data_p1;

  // Supervisor bit passes through; the increment wraps inside the low field.
  function automatic logic [DATA_W-1:0] link_value(input logic [DATA_W-1:0] pc);
    logic [DATA_W-2:0] low;
    low = pc[DATA_W-2:0] + (DATA_W-1)'(PC_INC);
    return {pc[DATA_W-1], low};
  endfunction

  assign irq_take_p0 = (state == RUN) && IRQ && !PC[DATA_W-1];

`ifdef WB_ROUND_ROBIN_EN
  localparam logic PORT_ALU = 1'b0;
  localparam logic PORT_MEM = 1'b1;

  logic rr_ptr;

  always_comb begin
    alu_gnt_p0 = 1'b0;
    mem_gnt_p0 = 1'b0;
    if (!irq_take_p0) begin
      if (alu_valid && mem_valid) begin
        mem_gnt_p0 = (rr_ptr == PORT_MEM);
        alu_gnt_p0 = (rr_ptr == PORT_ALU);
      end else begin
        alu_gnt_p0 = alu_valid;
        mem_gnt_p0 = mem_valid;
      end
    end
  end

  // Preference always moves to the port that was not just served.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= PORT_MEM;
    end else if (alu_gnt_p0) begin
      rr_ptr <= PORT_MEM;
    end else if (mem_gnt_p0) begin
      rr_ptr <= PORT_ALU;
    end
  end
`else
  always_comb begin
    alu_gnt_p0 = 1'b0;
    mem_gnt_p0 = 1'b0;
    if (!irq_take_p0) begin
      mem_gnt_p0 = mem_valid;
      alu_gnt_p0 = alu_valid && !mem_valid;
    end
  end
`endif

  assign alu_ready = alu_gnt_p0;
  assign mem_ready = mem_gnt_p0;

  always_comb begin
    sel_addr_p0 = '0;
    sel_data_p0 = '0;
    vld_p0      = 1'b0;
    if (irq_take_p0) begin
      sel_addr_p0 = ADDR_W'(LINK_REG);
      sel_data_p0 = link_value(PC);
      vld_p0      = 1'b1;
    end else if (mem_gnt_p0) begin
      sel_addr_p0 = mem_addr;
      sel_data_p0 = mem_data;
      vld_p0      = (mem_addr != '0);
    end else if (alu_gnt_p0) begin
      sel_addr_p0 = alu_addr;
      sel_data_p0 = alu_data;
      vld_p0      = (alu_addr != '0);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (irq_take_p0) state_nxt = HOLD;
      HOLD:    if (!IRQ || PC[DATA_W-1]) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- stage p0 -> p1: register-file write port ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      ack_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= vld_p0;
      ack_p1  <= irq_take_p0;
      addr_p1 <= sel_addr_p0;
      data_p1 <= sel_data_p0;
    end
  end

  assign WrC        = vld_p1;
  assign irq_ack    = ack_p1;
  assign AddrC      = addr_p1;
  assign WriteDataC = data_p1;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; expectations written out by hand per step.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, IRQ;
  logic [4:0]  alu_addr, mem_addr;
  logic [31:0] alu_data, mem_data, PC;
  logic        alu_ready, mem_ready, irq_ack, WrC;
  logic [4:0]  AddrC;
  logic [31:0] WriteDataC;

  int vectors = 0;
  int miscompares = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .IRQ(IRQ), .PC(PC), .irq_ack(irq_ack),
    .WrC(WrC), .AddrC(AddrC), .WriteDataC(WriteDataC)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; IRQ = 1'b0; PC = 32'h0;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'hAA;
    mem_valid = 1'b0; mem_addr = 5'd0; mem_data = 32'h0;

    // 1: reset held two cycles with an ALU request pending
    tick();
    chk("rst1_wrc", 32'(WrC), 32'd0);
    chk("rst1_ack", 32'(irq_ack), 32'd0);
    chk("rst1_addr", 32'(AddrC), 32'd0);
    tick();
    chk("rst2_wrc", 32'(WrC), 32'd0);
    chk("rst2_data", WriteDataC, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    chk("post_rst_wrc", 32'(WrC), 32'd1);
    chk("post_rst_addr", 32'(AddrC), 32'd7);
    chk("post_rst_data", WriteDataC, 32'hAA);

    // 2: lone ALU write
    alu_addr = 5'd5; alu_data = 32'h1234;
    #1;
    chk("alu_ready", 32'(alu_ready), 32'd1);
    tick();
    chk("alu_wrc", 32'(WrC), 32'd1);
    chk("alu_addr", 32'(AddrC), 32'd5);
    chk("alu_data", WriteDataC, 32'h00001234);
    alu_valid = 1'b0;
    tick();
    chk("idle_wrc", 32'(WrC), 32'd0);

    // 3: both requesters for four cycles
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h33;
    mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'h44;
    for (int i = 0; i < 4; i++) begin
      #1;
`ifdef WB_ROUND_ROBIN_EN
      chk("both_mem_ready", 32'(mem_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("both_alu_ready", 32'(alu_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      chk("both_addr", 32'(AddrC), (i % 2 == 0) ? 32'd4 : 32'd3);
`else
      chk("both_mem_ready", 32'(mem_ready), 32'd1);
      chk("both_alu_ready", 32'(alu_ready), 32'd0);
      tick();
      chk("both_addr", 32'(AddrC), 32'd4);
`endif
      chk("both_wrc", 32'(WrC), 32'd1);
    end

    // 4: IRQ beats both requesters; held IRQ gives a single link save
    IRQ = 1'b1; PC = 32'h00400010;
    #1;
    chk("irq_alu_ready", 32'(alu_ready), 32'd0);
    chk("irq_mem_ready", 32'(mem_ready), 32'd0);
    tick();
    chk("irq_wrc", 32'(WrC), 32'd1);
    chk("irq_addr", 32'(AddrC), 32'd31);
    chk("irq_data", WriteDataC, 32'h00400014);
    chk("irq_ack", 32'(irq_ack), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_ack", 32'(irq_ack), 32'd0);
      chk("hold_wrc", 32'(WrC), 32'd1);
`ifdef WB_ROUND_ROBIN_EN
      chk("hold_addr", 32'(AddrC), (i % 2 == 0) ? 32'd4 : 32'd3);
`else
      chk("hold_addr", 32'(AddrC), 32'd4);
`endif
    end
    IRQ = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    tick();
    chk("irq_drop_wrc", 32'(WrC), 32'd0);
    chk("irq_drop_ack", 32'(irq_ack), 32'd0);

    // 5: supervisor mode masks IRQ; then link value wraps inside bits 30:0
    IRQ = 1'b1; PC = 32'h80000020;
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h99;
    #1;
    chk("sup_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    chk("sup_ack", 32'(irq_ack), 32'd0);
    chk("sup_addr", 32'(AddrC), 32'd9);
    chk("sup_data", WriteDataC, 32'h99);
    PC = 32'h7FFFFFFC;
    #1;
    chk("wrap_alu_ready", 32'(alu_ready), 32'd0);
    tick();
    chk("wrap_wrc", 32'(WrC), 32'd1);
    chk("wrap_addr", 32'(AddrC), 32'd31);
    chk("wrap_data", WriteDataC, 32'h00000000);
    chk("wrap_ack", 32'(irq_ack), 32'd1);
    IRQ = 1'b0; alu_valid = 1'b0;
    tick();
    chk("wrap_after_ack", 32'(irq_ack), 32'd0);

    // 6: write to register 0 is accepted but suppressed
    mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'hFFFF;
    #1;
    chk("r0_mem_ready", 32'(mem_ready), 32'd1);
    tick();
    chk("r0_wrc", 32'(WrC), 32'd0);
    mem_valid = 1'b0;

    // reset coincident with a grant drops the write
    alu_valid = 1'b1; alu_addr = 5'd6; alu_data = 32'h66;
    reset = 1'b1;
    tick();
    chk("rst_mid_wrc", 32'(WrC), 32'd0);
    chk("rst_mid_addr", 32'(AddrC), 32'd0);
    reset = 1'b0; alu_valid = 1'b0;
    tick();
    chk("rst_mid_after", 32'(WrC), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
